mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_pkg.sv | 17 +
 rtl/mux_arbiter_rr_pick.sv | 31 +++
 rtl/mux_arbiter.sv | 108 ++++++++++
 tb/tb_mux_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [0:0] {IDLE, OWNED} state_e;

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Rotating-priority pick: first masked request scanning ptr, ptr+1, ... modulo NUM_REQ.
module rr_pick
    import mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   pos;

    assign cand = req & mask;

    // Walk from the farthest slot back to ptr so the nearest candidate is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time and a registered data mux.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] d,
    output logic [NUM_REQ-1:0]        grant,
    output logic [SEL_W-1:0]          select,
    output logic [DATA_W-1:0]         q,
    output logic                      q_valid
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [SEL_W-1:0]   select_d;
    logic               valid_d;
    logic [DATA_W-1:0]  lane;

    logic [NUM_REQ-1:0] pick_mask;
    logic [SEL_W-1:0]   pick_ptr;
    logic               found;
    logic [SEL_W-1:0]   idx;

    // While owned, the pick excludes the owner and starts just after it, so
    // found doubles as "another requester is pending".
    assign pick_mask = (state_q == OWNED) ? ~to_onehot(select) : '1;
    assign pick_ptr  = (state_q == OWNED) ? select + SEL_W'(1) : ptr_q;
    assign lane      = d[select*DATA_W +: DATA_W];

    rr_pick u_pick (
        .req   (req),
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = grant;
        select_d = select;
        valid_d  = (grant != '0) && req[select];
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = OWNED;
                    grant_d  = to_onehot(idx);
                    select_d = idx;
                    cnt_d    = CNT_W'(1);
                end
            end
            OWNED: begin
                if (!req[select] || (cnt_q == HOLD_LIM && found)) begin
                    ptr_d = select + SEL_W'(1);
                    if (found) begin
                        grant_d  = to_onehot(idx);
                        select_d = idx;
                        cnt_d    = CNT_W'(1);
                    end else begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        select_d = '0;
                        cnt_d    = '0;
                    end
                end else if (cnt_q == HOLD_LIM) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant   <= '0;
            select  <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant   <= grant_d;
            select  <= select_d;
            q_valid <= valid_d;
            if (valid_d) begin
                q <= lane;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed vector table, corner sequences, random vs model.
module tb_mux_arbiter;

    localparam int DW = 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = '0;
    logic [4*DW-1:0] d = '0;
    logic [3:0]    grant;
    logic [1:0]    select;
    logic [DW-1:0] q;
    logic          q_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 when idle), hold count, rotation pointer.
    int         m_owner;
    int         m_cnt;
    int         m_ptr;
    logic [7:0] m_q;
    logic       m_qv;

    mux_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .grant   (grant),
        .select  (select),
        .q       (q),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [1:0] s;
        logic [7:0] qq;
        logic       qv;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int scan(input logic [3:0] r, input int excl, input int start);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_q     = '0;
        m_qv    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [4*DW-1:0] dv);
        int  w;
        bit  others;
        bit  valid;
        valid = (m_owner >= 0) && r[m_owner];
        if (valid) m_q = dv[m_owner*8 +: 8];
        m_qv = valid;
        if (m_owner < 0) begin
            w = scan(r, -1, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 1;
            end
        end else begin
            others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            if (!r[m_owner] || (m_cnt == MH && others)) begin
                m_ptr = (m_owner + 1) % 4;
                w     = scan(r, m_owner, m_ptr);
                m_owner = w;
                m_cnt   = (w >= 0) ? 1 : 0;
            end else begin
                m_cnt = (m_cnt == MH) ? 1 : m_cnt + 1;
            end
        end
    endtask

    task automatic run_cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [3:0] eg;
        logic [1:0] es;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        es = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".select"}, 32'(select), 32'(es));
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".q_valid"}, 32'(q_valid), 32'(m_qv));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t       vt[8];
        logic [3:0] r;

        // Directed table: lane0=11 lane1=22 lane2=A5 lane3=33.
        vt[0] = '{4'b0100, 4'b0100, 2'd2, 8'h00, 1'b0};
        vt[1] = '{4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1};
        vt[2] = '{4'b0000, 4'b0000, 2'd0, 8'hA5, 1'b0};
        vt[3] = '{4'b0000, 4'b0000, 2'd0, 8'hA5, 1'b0};
        vt[4] = '{4'b1011, 4'b1000, 2'd3, 8'hA5, 1'b0};
        vt[5] = '{4'b1011, 4'b1000, 2'd3, 8'h33, 1'b1};
        vt[6] = '{4'b0011, 4'b0001, 2'd0, 8'h33, 1'b0};
        vt[7] = '{4'b0011, 4'b0001, 2'd0, 8'h11, 1'b1};

        d = {8'h33, 8'hA5, 8'h22, 8'h11};
        do_reset();
        chk("reset.grant", 32'(grant), 32'h0);
        chk("reset.select", 32'(select), 32'h0);
        chk("reset.q", 32'(q), 32'h0);
        chk("reset.q_valid", 32'(q_valid), 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_cycle(vt[i].r);
            chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(vt[i].g));
            chk($sformatf("vec%0d.select", i), 32'(select), 32'(vt[i].s));
            chk($sformatf("vec%0d.q", i), 32'(q), 32'(vt[i].qq));
            chk($sformatf("vec%0d.q_valid", i), 32'(q_valid), 32'(vt[i].qv));
        end

        // Fairness: all requesting, each owner holds MH cycles in rotation.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            run_cycle(4'b1111);
            chk($sformatf("fair%0d.grant", k), 32'(grant), 32'(4'b0001 << ((k / MH) % 4)));
        end

        // Sole holder never loses the grant.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            run_cycle(4'b0001);
            chk($sformatf("sole%0d.grant", k), 32'(grant), 32'h1);
        end

        // Early drop: owner 1 releases after 2 cycles, requester 3 waiting.
        do_reset();
        run_cycle(4'b0010);
        chk("drop.grant1", 32'(grant), 32'h2);
        run_cycle(4'b1010);
        run_cycle(4'b1010);
        chk("drop.grant1b", 32'(grant), 32'h2);
        run_cycle(4'b1000);
        chk("drop.grant3", 32'(grant), 32'h8);
        chk("drop.ptr", 32'(dut.ptr_q), 32'h2);

        // Asynchronous reset mid-ownership.
        run_cycle(4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.grant", 32'(grant), 32'h0);
        chk("areset.select", 32'(select), 32'h0);
        chk("areset.q", 32'(q), 32'h0);
        chk("areset.q_valid", 32'(q_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(4'b1010);
        chk("areset.owner1", 32'(grant), 32'h2);

        // Randomised traffic against the reference model.
        do_reset();
        r = '0;
        for (int k = 0; k < 400; k++) begin
            r = r ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            d = 32'($urandom);
            run_cycle(r);
            chk_model($sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
